// File: rtl/sample_streamer_pkg.sv
// sample_streamer_pkg: ROM word field positions, unpacked sample struct and FSM state codes
package sample_streamer_pkg;

    localparam int X_MSB     = 17;
    localparam int X_LSB     = 10;
    localparam int Y_MSB     = 9;
    localparam int Y_LSB     = 2;
    localparam int CLASS_BIT = 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       label;
    } sample_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_LOAD    = 3'd2;
    localparam state_t ST_PRESENT = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    function automatic sample_t unpack_sample(input logic [X_MSB:CLASS_BIT] w);
        return '{x: w[X_MSB:X_LSB], y: w[Y_MSB:Y_LSB], label: w[CLASS_BIT]};
    endfunction

endpackage

// File: rtl/sample_streamer.sv
// sample_streamer: walks the sample ROM in stride-permuted order and streams unpacked samples for N epochs
module sample_streamer
    import sample_streamer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 18,
    parameter int ADDR_WIDTH   = 6,
    parameter int STRIDE       = 37,
    parameter int EPOCH_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [EPOCH_WIDTH-1:0]  num_epochs,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [SAMPLE_WIDTH-1:0] mem_data,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic [7:0]              s_x,
    output logic [7:0]              s_y,
    output logic                    s_label,
    output logic                    s_last,
    output logic [EPOCH_WIDTH-1:0]  s_epoch,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_WIDTH-1:0]  IDX_MAX   = '1;
    localparam logic [ADDR_WIDTH-1:0]  IDX_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  STEP      = ADDR_WIDTH'(STRIDE);
    localparam logic [EPOCH_WIDTH-1:0] EPOCH_ONE = EPOCH_WIDTH'(1);

    state_t                 state, state_n;
    logic [ADDR_WIDTH-1:0]  idx, idx_n;
    logic [EPOCH_WIDTH-1:0] epoch, count;
    logic                   hs, epoch_end, run_end, to_issue, pad_unused;
    sample_t                smp;

    assign pad_unused = mem_data[0];
    assign s_valid    = state == ST_PRESENT;
    assign busy       = state != ST_IDLE;
    assign done       = state == ST_DONE;

    always_comb begin
        hs        = state == ST_PRESENT && s_ready;
        epoch_end = idx == IDX_MAX;
        run_end   = epoch_end && (epoch + EPOCH_ONE) == count;
        idx_n     = state == ST_IDLE ? '0 : idx + IDX_ONE;
        state_n   = state == ST_IDLE    ? (start ? (num_epochs == '0 ? ST_DONE : ST_ISSUE) : ST_IDLE)
                  : state == ST_ISSUE   ? ST_LOAD
                  : state == ST_LOAD    ? ST_PRESENT
                  : state == ST_PRESENT ? (!s_ready ? ST_PRESENT : run_end ? ST_DONE : ST_ISSUE)
                  : ST_IDLE;
        to_issue  = state_n == ST_ISSUE;
        smp       = unpack_sample(mem_data[X_MSB:CLASS_BIT]);
    end

    // mem_addr is loaded on entry to ISSUE so the ROM sees a registered address for the whole cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            epoch    <= '0;
            count    <= '0;
            mem_addr <= '0;
            s_x      <= '0;
            s_y      <= '0;
            s_label  <= 1'b0;
            s_last   <= 1'b0;
            s_epoch  <= '0;
        end else begin
            state <= state_n;
            if (to_issue)
                mem_addr <= ADDR_WIDTH'(idx_n * STEP);
            if (state == ST_IDLE && start) begin
                count <= num_epochs;
                idx   <= '0;
                epoch <= '0;
            end
            if (state == ST_LOAD) begin
                s_x     <= smp.x;
                s_y     <= smp.y;
                s_label <= smp.label;
                s_last  <= epoch_end;
                s_epoch <= epoch;
            end
            if (hs) begin
                idx <= idx + IDX_ONE;
                if (epoch_end)
                    epoch <= epoch + EPOCH_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: directed checks of the stride-permuted sample streamer against a behavioural ROM
module tb_sample_streamer;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, s_ready = 1'b0;
    logic [7:0]  num_epochs = '0;
    logic [5:0]  mem_addr;
    logic [17:0] mem_data;
    logic        s_valid, s_label, s_last, busy, done;
    logic [7:0]  s_x, s_y, s_epoch;
    logic [17:0] rom [64];
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= rom[mem_addr];

    sample_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_epochs(num_epochs),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .s_label(s_label), .s_last(s_last), .s_epoch(s_epoch),
        .busy(busy), .done(done)
    );

    task automatic start_pulse(input logic [7:0] n);
        @(negedge clk);
        start = 1'b1;
        num_epochs = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({mem_addr, s_valid, s_x, s_y, s_label, s_last, s_epoch, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got addr=%h v=%b x=%h y=%h l=%b last=%b ep=%h busy=%b done=%b, want all 0",
                     mem_addr, s_valid, s_x, s_y, s_label, s_last, s_epoch, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, s_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b done=%b v=%b, want 000", busy, done, s_valid);
        end
    endtask

    task automatic test_first_samples;
        bit seen_done = 1'b0;
        s_ready = 1'b0;
        start_pulse(8'd1);
        vectors++;
        if ({busy, s_valid, mem_addr} !== {1'b1, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL cycle1: got busy=%b v=%b addr=%0d, want busy=1 v=0 addr=0", busy, s_valid, mem_addr);
        end
        @(negedge clk);
        vectors++;
        if (s_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cycle2_valid: got %b want 0", s_valid);
        end
        @(negedge clk);
        vectors++;
        if ({s_valid, s_x, s_y, s_label, s_last, s_epoch} !== {1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL sample0: got v=%b x=%h y=%h l=%b last=%b ep=%0d, want v=1 x=f0 y=f0 l=0 last=0 ep=0",
                     s_valid, s_x, s_y, s_label, s_last, s_epoch);
        end
        s_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_valid, mem_addr} !== {1'b0, 6'd37}) begin
            miscompares++;
            $display("FAIL issue1: got v=%b addr=%0d, want v=0 addr=37", s_valid, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({s_valid, s_x, s_y, s_label} !== {1'b1, 8'h15, 8'h0B, 1'b1}) begin
            miscompares++;
            $display("FAIL sample1: got v=%b x=%h y=%h l=%b, want v=1 x=15 y=0b l=1", s_valid, s_x, s_y, s_label);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_valid, mem_addr, s_x, s_y, s_label} !== {1'b1, 6'd10, 8'hF9, 8'hED, 1'b0}) begin
            miscompares++;
            $display("FAIL sample2: got v=%b addr=%0d x=%h y=%h l=%b, want v=1 addr=10 x=f9 y=ed l=0",
                     s_valid, mem_addr, s_x, s_y, s_label);
        end
        for (int i = 0; i < 400 && !seen_done; i++) begin
            @(negedge clk);
            seen_done = done;
        end
        vectors++;
        if (!seen_done) begin
            miscompares++;
            $display("FAIL first_run_done: got no done pulse within 400 cycles, want one");
        end
        @(negedge clk);
    endtask

    task automatic run_epochs(input logic [7:0] n, input bit bp, input bit poke, input string tag);
        int          total = int'(n) * 64;
        int          hs = 0, cyc = 0, lasts = 0, k, a;
        logic [63:0] seen = '0;
        logic [32:0] snap = '0;
        bit          stalled = 1'b0;
        start_pulse(n);
        num_epochs = 8'd99;
        while (hs < total && cyc < total * 8 + 50) begin
            if (stalled) begin
                vectors++;
                if ({s_valid, mem_addr, s_x, s_y, s_label, s_last, s_epoch} !== snap) begin
                    miscompares++;
                    $display("FAIL %s_stall_hold: got %h want %h at cycle %0d", tag,
                             {s_valid, mem_addr, s_x, s_y, s_label, s_last, s_epoch}, snap, cyc);
                end
            end
            start   = poke && cyc == 20;
            s_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_valid && s_ready) begin
                k = hs % 64;
                a = (k * 37) % 64;
                vectors++;
                if (mem_addr !== 6'(a) || s_x !== rom[a][17:10] || s_y !== rom[a][9:2] ||
                    s_label !== rom[a][1] || s_epoch !== 8'(hs / 64) || s_last !== (k == 63)) begin
                    miscompares++;
                    $display("FAIL %s_sample%0d: got addr=%0d x=%h y=%h l=%b ep=%0d last=%b, want addr=%0d x=%h y=%h l=%b ep=%0d last=%b",
                             tag, hs, mem_addr, s_x, s_y, s_label, s_epoch, s_last,
                             a, rom[a][17:10], rom[a][9:2], rom[a][1], hs / 64, k == 63);
                end
                if (s_last) lasts++;
                seen[a] = 1'b1;
                hs++;
            end
            stalled = s_valid && !s_ready;
            snap    = {s_valid, mem_addr, s_x, s_y, s_label, s_last, s_epoch};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (hs != total) begin
            miscompares++;
            $display("FAIL %s_handshakes: got %0d want %0d (cycle budget ran out)", tag, hs, total);
        end
        vectors++;
        if (lasts != int'(n) || seen !== '1) begin
            miscompares++;
            $display("FAIL %s_coverage: got lasts=%0d seen=%h, want lasts=%0d seen=all ones", tag, lasts, seen, n);
        end
        vectors++;
        if ({done, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL %s_done_pulse: got done=%b busy=%b, want 1 1", tag, done, busy);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, s_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s_idle_after: got done=%b busy=%b v=%b, want 000", tag, done, busy, s_valid);
        end
    endtask

    task automatic test_full_epoch;
        run_epochs(8'd1, 1'b0, 1'b0, "full_epoch");
    endtask

    task automatic test_backpressure;
        run_epochs(8'd3, 1'b1, 1'b0, "backpressure");
    endtask

    task automatic test_start_while_busy;
        run_epochs(8'd2, 1'b0, 1'b1, "start_busy");
    endtask

    task automatic test_zero_epochs;
        start_pulse(8'd0);
        vectors++;
        if ({done, busy, s_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL zero_done: got done=%b busy=%b v=%b, want 1 1 0", done, busy, s_valid);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, s_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_idle: got done=%b busy=%b v=%b, want 000", done, busy, s_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        bit got_valid = 1'b0, got_done = 1'b0;
        s_ready = 1'b0;
        start_pulse(8'd1);
        for (int i = 0; i < 10 && !got_valid; i++) begin
            got_valid = s_valid;
            if (!got_valid) @(negedge clk);
        end
        vectors++;
        if (!got_valid) begin
            miscompares++;
            $display("FAIL midrun_present: got s_valid=0 after 10 cycles, want 1");
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_addr, s_valid, s_x, s_y, s_label, s_last, s_epoch, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL midrun_async_reset: got addr=%h v=%b x=%h y=%h l=%b last=%b ep=%h busy=%b done=%b, want all 0",
                     mem_addr, s_valid, s_x, s_y, s_label, s_last, s_epoch, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got_done |= done;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got_done |= done;
        end
        vectors++;
        if (got_done) begin
            miscompares++;
            $display("FAIL midrun_no_done: got done pulse after reset, want none");
        end
        run_epochs(8'd1, 1'b0, 1'b0, "restart");
    endtask

    initial begin
        for (int a = 0; a < 64; a++)
            rom[a] = {8'(a * 7 + 3), 8'(a * 5 + 1), (a >= 32) ? 1'b1 : 1'b0, 1'b0};
        rom[0]  = {8'hF0, 8'hF0, 1'b0, 1'b1};
        rom[37] = {8'h15, 8'h0B, 1'b1, 1'b0};
        rom[10] = {8'hF9, 8'hED, 1'b0, 1'b1};
        test_reset;
        test_first_samples;
        test_full_epoch;
        test_backpressure;
        test_zero_epochs;
        test_start_while_busy;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
